tof_readout: RTL and testbench

TOF_READOUT -- requirements
Module: tof_readout

---
 rtl/tof_rd_pkg.sv | 38 +++
 rtl/tof_rd_timer.sv | 29 ++
 rtl/tof_readout.sv | 139 +++++++++++++
 tb/tb_tof_readout.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tof_rd_pkg.sv
// Shared constants for the TOF readout framer: FSM encoding,
// header field layout, data widths and the out-of-range code.
package tof_rd_pkg;

    localparam int FID_W = 10;
    localparam int TOF_W = 15;
    localparam int RD_W  = 16;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_COLLECT    = 3'd2;
    localparam logic [2:0] ST_EMIT_HDR   = 3'd3;
    localparam logic [2:0] ST_EMIT_HIT   = 3'd4;

    localparam int HDR_TAG_BIT   = 15;
    localparam int HDR_NV_LSB    = 13;
    localparam int HDR_ND_LSB    = 11;
    localparam int HDR_TRUNC_BIT = 10;

    localparam logic [TOF_W-1:0] TOF_INVALID = 15'h7FFF;

    function automatic logic [RD_W-1:0] mk_hdr(
        input logic [1:0]       nv,
        input logic [1:0]       nd,
        input logic             tr,
        input logic [FID_W-1:0] fid
    );
        logic [RD_W-1:0] h;
        h                      = '0;
        h[HDR_TAG_BIT]         = 1'b1;
        h[HDR_NV_LSB +: 2]     = nv;
        h[HDR_ND_LSB +: 2]     = nd;
        h[HDR_TRUNC_BIT]       = tr;
        h[FID_W-1:0]           = fid;
        return h;
    endfunction

endpackage

// File: rtl/tof_rd_timer.sv
// Collect-window timer: load clears, enable counts,
// expire holds once the count reaches TIMEOUT-1.
module tof_rd_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expire = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tof_readout.sv
// TOF frame builder: gathers up to three stop hits per trigger
// and streams a header word followed by the stored hits.
module tof_readout
    import tof_rd_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tri_en,
    input  logic             hit_valid,
    input  logic [TOF_W-1:0] hit_data,
    output logic             rd_valid,
    output logic [RD_W-1:0]  rd_data,
    input  logic             rd_ready,
    output logic             frame_done,
    output logic             overflow,
    input  logic             clr_ovf
);

    logic [2:0]       state;
    logic [1:0]       n_valid;
    logic [1:0]       n_drop;
    logic [1:0]       rd_idx;
    logic             trunc;
    logic [FID_W-1:0] frame_id;
    logic [TOF_W-1:0] slot [3];

    logic expire;
    logic xfer;
    logic last_hit;
    logic hit_ok;
    logic hit_bad;
    logic full_next;

    assign xfer      = rd_valid && rd_ready;
    assign last_hit  = (rd_idx == n_valid - 2'd1);
    assign hit_ok    = hit_valid && (hit_data != TOF_INVALID);
    assign hit_bad   = hit_valid && (hit_data == TOF_INVALID);
    // any accepted hit brings the total up by one
    assign full_next = hit_valid &&
                       (({1'b0, n_valid} + {1'b0, n_drop}) == 3'd2);

    tof_rd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == ST_WAIT_START && hit_valid && !tri_en),
        .en     (state == ST_COLLECT),
        .expire (expire)
    );

    assign rd_valid   = (state == ST_EMIT_HDR) || (state == ST_EMIT_HIT);
    assign frame_done = xfer &&
                        (((state == ST_EMIT_HDR) && (n_valid == 2'd0)) ||
                         ((state == ST_EMIT_HIT) && last_hit));

    always_comb begin
        rd_data = '0;
        if (state == ST_EMIT_HDR) begin
            rd_data = mk_hdr(n_valid, n_drop, trunc, frame_id);
        end else if (state == ST_EMIT_HIT) begin
            rd_data = {1'b0, slot[rd_idx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            n_valid  <= '0;
            n_drop   <= '0;
            rd_idx   <= '0;
            trunc    <= 1'b0;
            frame_id <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < 3; i++) slot[i] <= '0;
        end else begin
            // a lost trigger outranks a same-cycle clear
            if (tri_en && state != ST_IDLE) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (tri_en) begin
                        state    <= ST_WAIT_START;
                        n_valid  <= '0;
                        n_drop   <= '0;
                        trunc    <= 1'b0;
                        rd_idx   <= '0;
                        frame_id <= frame_id + 1'b1;
                    end
                end
                ST_WAIT_START: begin
                    if (tri_en) begin
                        trunc <= 1'b1;
                        state <= ST_EMIT_HDR;
                    end else if (hit_valid) begin
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (tri_en) begin
                        trunc <= 1'b1;
                        state <= ST_EMIT_HDR;
                    end else begin
                        if (hit_ok) begin
                            slot[n_valid] <= hit_data;
                            n_valid       <= n_valid + 2'd1;
                        end
                        if (hit_bad && n_drop != 2'd3) begin
                            n_drop <= n_drop + 2'd1;
                        end
                        if (full_next) begin
                            state <= ST_EMIT_HDR;
                        end else if (expire) begin
                            trunc <= 1'b1;
                            state <= ST_EMIT_HDR;
                        end
                    end
                end
                ST_EMIT_HDR: begin
                    if (xfer) begin
                        rd_idx <= '0;
                        state  <= (n_valid != 2'd0) ? ST_EMIT_HIT : ST_IDLE;
                    end
                end
                ST_EMIT_HIT: begin
                    if (xfer) begin
                        if (last_hit) state <= ST_IDLE;
                        else          rd_idx <= rd_idx + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tof_readout.sv
// Directed bench for tof_readout with a word scoreboard
// checked at every accepted readout word.
module tb_tof_readout;

    typedef struct {
        logic [15:0] word;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tri_en = 1'b0;
    logic        hit_valid = 1'b0;
    logic [14:0] hit_data = '0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready = 1'b0;
    logic        frame_done;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int          vectors = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [15:0] last_hdr = '0;

    always #5 clk = ~clk;

    tof_readout #(.TIMEOUT(1023)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tri_en     (tri_en),
        .hit_valid  (hit_valid),
        .hit_data   (hit_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .frame_done (frame_done),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    function automatic logic [15:0] hdr(input int nv, input int nd,
                                        input int tr, input int fid);
        logic [1:0] v;
        logic [1:0] d;
        logic [9:0] f;
        v = nv[1:0];
        d = nd[1:0];
        f = fid[9:0];
        return {1'b1, v, d, tr[0], f};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rd_valid && rd_ready) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word obs=%h exp=none", rd_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                assert (rd_data === e.word) else begin
                    errors++;
                    $error("FAIL word obs=%h exp=%h", rd_data, e.word);
                end
                vectors++;
                assert (frame_done === e.last) else begin
                    errors++;
                    $error("FAIL frame_done obs=%b exp=%b word=%h",
                           frame_done, e.last, e.word);
                end
                if (rd_data[15]) last_hdr = rd_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w, input logic l);
        exp_t e;
        e.word = w;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic trig();
        tri_en = 1'b1;
        tick();
        tri_en = 1'b0;
    endtask

    task automatic hit(input logic [14:0] d);
        hit_valid = 1'b1;
        hit_data  = d;
        tick();
        hit_valid = 1'b0;
        hit_data  = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        tick();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!rd_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid", {31'd0, rd_valid}, 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_rd_data", {16'd0, rd_data}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        rst_n = 1'b1;
        tick();
        rd_ready = 1'b1;

        // three valid stops: n_valid=3 lands in [14:13]
        push(hdr(3, 0, 0, 1), 1'b0);
        push(16'h0123, 1'b0);
        push(16'h0456, 1'b0);
        push(16'h0789, 1'b1);
        trig();
        hit(15'h0001);
        hit(15'h0123);
        hit(15'h0456);
        hit(15'h0789);
        drain(20);

        push(hdr(2, 1, 0, 2), 1'b0);
        push(16'h0100, 1'b0);
        push(16'h0200, 1'b1);
        trig();
        hit(15'h0002);
        hit(15'h0100);
        hit(15'h7FFF);
        hit(15'h0200);
        drain(20);
        chk("ovf_clean", {31'd0, overflow}, 0);

        push(hdr(1, 0, 1, 3), 1'b0);
        push(16'h0050, 1'b1);
        trig();
        hit(15'h0003);
        hit(15'h0050);
        repeat (500) tick();
        chk("no_early_close", {31'd0, rd_valid}, 0);
        drain(1100);

        rd_ready = 1'b0;
        push(hdr(3, 0, 0, 4), 1'b0);
        push(16'h0011, 1'b0);
        push(16'h0022, 1'b0);
        push(16'h0033, 1'b1);
        trig();
        hit(15'h0004);
        hit(15'h0011);
        hit(15'h0022);
        hit(15'h0033);
        wait_valid(10);
        for (int i = 0; i < 20; i++) begin
            chk("stall_hold", {16'd0, rd_data}, {16'd0, hdr(3, 0, 0, 4)});
            if (i == 5) trig();
            else tick();
        end
        chk("stall_ovf_set", {31'd0, overflow}, 1);
        chk("stall_valid", {31'd0, rd_valid}, 1);
        tri_en  = 1'b1;
        clr_ovf = 1'b1;
        tick();
        tri_en  = 1'b0;
        clr_ovf = 1'b0;
        chk("ovf_clr_race", {31'd0, overflow}, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 0);
        rd_ready = 1'b1;
        drain(20);

        push(hdr(0, 0, 1, 5), 1'b1);
        trig();
        trig();
        drain(20);
        chk("lost_trig_ovf", {31'd0, overflow}, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        hit(15'h0123);
        repeat (3) tick();
        chk("idle_hit_ignored", {31'd0, rd_valid}, 0);

        for (int f = 6; f <= 1025; f++) begin
            push(hdr(0, 3, 0, f), 1'b1);
            trig();
            hit(15'h0005);
            hit(15'h7FFF);
            hit(15'h7FFF);
            hit(15'h7FFF);
            drain(20);
        end
        chk("wrap_fid", {22'd0, last_hdr[9:0]}, 1);

        rd_ready = 1'b0;
        push(hdr(3, 0, 0, 2), 1'b0);
        trig();
        hit(15'h0006);
        hit(15'h0AAA);
        hit(15'h0BBB);
        hit(15'h0CCC);
        wait_valid(10);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("emit_hit_valid", {31'd0, rd_valid}, 1);
        chk("emit_hit_data", {16'd0, rd_data}, 32'h0AAA);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, rd_valid}, 0);
        chk("async_rst_data", {16'd0, rd_data}, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        rd_ready = 1'b1;
        repeat (5) tick();
        chk("post_rst_quiet", {31'd0, rd_valid}, 0);

        push(hdr(3, 0, 0, 1), 1'b0);
        push(16'h0101, 1'b0);
        push(16'h0202, 1'b0);
        push(16'h0303, 1'b1);
        trig();
        hit(15'h0007);
        hit(15'h0101);
        hit(15'h0202);
        hit(15'h0303);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
